// File: rtl/tbl_rd_arb.sv
// Shared FP lookup-table owner: streams the table in after reset/reload, then
// round-robin arbitrates two requesters onto the single combinational read port.
module tbl_rd_arb #(
    parameter int unsigned NUM_ENT = 320,
    parameter int unsigned TAG_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_start,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [67:0]      ld_data,
    output logic             ld_done,
    output logic             tbl_valid,
    input  logic             rq0_vld,
    input  logic             rq1_vld,
    output logic             rq0_rdy,
    output logic             rq1_rdy,
    input  logic [67:0]      rq0_A,
    input  logic [67:0]      rq1_A,
    input  logic [2:0]       rq0_xtra,
    input  logic [2:0]       rq1_xtra,
    input  logic [TAG_W-1:0] rq0_tag,
    input  logic [TAG_W-1:0] rq1_tag,
    output logic             rsp0_vld,
    output logic             rsp1_vld,
    output logic [67:0]      rsp0_res,
    output logic [67:0]      rsp1_res,
    output logic [TAG_W-1:0] rsp0_tag,
    output logic [TAG_W-1:0] rsp1_tag,
    output logic [67:0]      tbl_A,
    output logic [67:0]      tbl_B,
    output logic [2:0]       tbl_xtra,
    output logic             tbl_rd,
    output logic             tbl_wr,
    input  logic [67:0]      tbl_res
);

    localparam int unsigned IDX_W = $clog2(NUM_ENT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENT - 1);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] RDY   = 2'd2;

    logic [1:0]       state;
    logic [IDX_W-1:0] idx;
    logic             rr_last;
    logic             ld_acc;
    logic             arb_en;
    logic             g0;
    logic             g1;

    // Grants and load beats are held off while rst or ld_start is high, so no
    // request is consumed without its response being delivered.
    always_comb begin
        ld_ready = (state == LOAD) && !ld_start && !rst;
        ld_acc   = ld_ready && ld_valid;
        arb_en   = (state == RDY) && !ld_start && !rst;
        g0       = arb_en && rq0_vld && (!rq1_vld || rr_last);
        g1       = arb_en && rq1_vld && (!rq0_vld || !rr_last);
    end

    assign rq0_rdy   = g0;
    assign rq1_rdy   = g1;
    assign tbl_valid = (state == RDY);

    always_comb begin
        tbl_rd   = 1'b0;
        tbl_wr   = 1'b0;
        tbl_A    = '0;
        tbl_B    = '0;
        tbl_xtra = '0;
        if (ld_acc) begin
            tbl_wr              = 1'b1;
            tbl_A               = ld_data;
            tbl_B[45 +: IDX_W]  = idx;
        end else if (g0) begin
            tbl_rd   = 1'b1;
            tbl_A    = rq0_A;
            tbl_xtra = rq0_xtra;
        end else if (g1) begin
            tbl_rd   = 1'b1;
            tbl_A    = rq1_A;
            tbl_xtra = rq1_xtra;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= EMPTY;
            idx      <= '0;
            ld_done  <= 1'b0;
            rr_last  <= 1'b1;
            rsp0_vld <= 1'b0;
            rsp1_vld <= 1'b0;
            rsp0_res <= '0;
            rsp1_res <= '0;
            rsp0_tag <= '0;
            rsp1_tag <= '0;
        end else begin
            ld_done <= ld_acc && (idx == LAST_IDX);
            case (state)
                EMPTY: begin
                    if (ld_start) begin
                        state <= LOAD;
                        idx   <= '0;
                    end
                end
                LOAD: begin
                    if (ld_start) begin
                        idx <= '0;
                    end else if (ld_acc) begin
                        if (idx == LAST_IDX) begin
                            state <= RDY;
                            idx   <= '0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                RDY: begin
                    if (ld_start) begin
                        state <= LOAD;
                        idx   <= '0;
                    end
                end
                default: state <= EMPTY;
            endcase

            rsp0_vld <= g0;
            rsp1_vld <= g1;
            if (g0) begin
                rsp0_res <= tbl_res;
                rsp0_tag <= rq0_tag;
                rr_last  <= 1'b0;
            end
            if (g1) begin
                rsp1_res <= tbl_res;
                rsp1_tag <= rq1_tag;
                rr_last  <= 1'b1;
            end
        end
    end

endmodule
